// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache with a single-outstanding line refill.
// Optional hit/miss statistics counters are compiled in with `define ICACHE_STATS_EN.
module inst_fetch_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_F,
  output logic [31:0] inst_F,
  output logic        inst_mem_ack_F,
  input  logic        inv_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WB    = $clog2(WORDS_PER_LINE);
  localparam int LB    = $clog2(LINES);
  localparam int TAG_W = 32 - WB - LB - 2;
  localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAITDROP} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS_PER_LINE];

  logic [LB-1:0]     fill_line_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [WB-1:0]     cnt_q;
  logic [WB-1:0]     cnt_inc;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;

  logic [WB-1:0]     pc_word;
  logic [LB-1:0]     pc_line;
  logic [TAG_W-1:0]  pc_tag;
  logic              hit;
  logic              start_fill;
  logic              unused_byte_bits;

  assign pc_word          = pc_F[WB+1:2];
  assign pc_line          = pc_F[LB+WB+1:WB+2];
  assign pc_tag           = pc_F[31:LB+WB+2];
  assign unused_byte_bits = ^pc_F[1:0];

  // An invalidate in the same cycle suppresses the hit so no stale word escapes.
  assign hit        = (state_q == IDLE) && !inv_all && valid_q[pc_line] &&
                      (tag_q[pc_line] == pc_tag);
  assign start_fill = (state_q == IDLE) && !inv_all && !hit;
  assign cnt_inc    = cnt_q + WB'(1);

  assign inst_mem_ack_F = hit;
  assign inst_F         = hit ? data_q[pc_line][pc_word] : 32'h0;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fill_line_q <= '0;
      fill_tag_q  <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            valid_q <= '0;
          end else if (start_fill) begin
            fill_line_q      <= pc_line;
            fill_tag_q       <= pc_tag;
            cnt_q            <= '0;
            valid_q[pc_line] <= 1'b0;
            mem_req_q        <= 1'b1;
            mem_addr_q       <= {pc_F[31:WB+2], {WB{1'b0}}, 2'b00};
            state_q          <= FILL;
          end
        end
        FILL: begin
          if (inv_all) begin
            valid_q <= '0;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q   <= WAITDROP;
            end
          end else if (mem_ack) begin
            cnt_q      <= cnt_inc;
            mem_addr_q <= {fill_tag_q, fill_line_q, cnt_inc, 2'b00};
            if (cnt_q == LAST_WORD) begin
              valid_q[fill_line_q] <= 1'b1;
              mem_req_q            <= 1'b0;
              state_q              <= IDLE;
            end
          end
        end
        WAITDROP: begin
          // The request already issued must complete before the bus is released.
          if (inv_all) valid_q <= '0;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are intentionally not reset; the valid bits alone
  // decide whether their contents are used, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && mem_ack && !inv_all) begin
      data_q[fill_line_q][cnt_q] <= mem_rdata;
      if (cnt_q == LAST_WORD) tag_q[fill_line_q] <= fill_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      if (hit && (hit_count_q != 32'hFFFF_FFFF))
        hit_count_q <= hit_count_q + 32'd1;
      if (start_fill && (miss_count_q != 32'hFFFF_FFFF))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed bench for inst_fetch_cache: a latency-2 backing-memory responder plus
// table-driven hit vectors and hand-written fill, invalidate and reset sequences.
module tb_inst_fetch_cache;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_F;
  logic [31:0] inst_F;
  logic        inst_mem_ack_F;
  logic        inv_all;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack_r;
  logic        stray_ack;
  logic        mem_ack;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  assign mem_ack = mem_ack_r | stray_ack;

  inst_fetch_cache dut (
    .clk            (clk),
    .reset          (reset),
    .pc_F           (pc_F),
    .inst_F         (inst_F),
    .inst_mem_ack_F (inst_mem_ack_F),
    .inv_all        (inv_all),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          stab_err = 0;
  int          rsp_cnt = 0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] addr_log [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0040001) return 32'hA0 + 32'(a[3:2]);
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Backing memory: acks each request LAT cycles after it appears, one-cycle pulse.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      mem_ack_r = 1'b0;
      rsp_cnt   = 0;
    end else if (mem_ack_r) begin
      mem_ack_r = 1'b0;
      rsp_cnt   = 0;
    end else if (mem_req) begin
      if (rsp_cnt == 0) req_addr = mem_addr;
      else if (mem_addr !== req_addr) stab_err++;
      rsp_cnt++;
      if (rsp_cnt == LAT) begin
        mem_ack_r = 1'b1;
        mem_rdata = mem_word(mem_addr);
        addr_log.push_back(mem_addr);
      end
    end else begin
      rsp_cnt = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [31:0] pc, input string name);
    pc_F = pc;
    #1;
    check({name, " miss ack"}, 32'(inst_mem_ack_F), 32'h0);
    check({name, " miss inst"}, inst_F, 32'h0);
  endtask

  task automatic wait_hit(input logic [31:0] exp_inst, input int exp_cycles, input string name);
    int cyc   = 0;
    int gaps  = 0;
    int overl = 0;
    bit seen  = 1'b0;
    bit got   = 1'b0;
    while (cyc < 200 && !got) begin
      step();
      cyc++;
      if (mem_req) seen = 1'b1;
      if (mem_req && inst_mem_ack_F) overl++;
      if (seen && !mem_req && !inst_mem_ack_F) gaps++;
      if (inst_mem_ack_F) got = 1'b1;
    end
    check({name, " hit reached"}, 32'(got), 32'h1);
    check({name, " hit inst"}, inst_F, exp_inst);
    check({name, " req gaps"}, 32'(gaps), 32'h0);
    check({name, " ack during fill"}, 32'(overl), 32'h0);
    if (exp_cycles >= 0) check({name, " latency"}, 32'(cyc), 32'(exp_cycles));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        exp_ack;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t hits1 [3];
  vec_t hits2 [4];

  initial begin
    int base;
    int guard;

    hits1[0] = '{32'h0040_0014, 1'b1, 32'hA1};
    hits1[1] = '{32'h0040_0018, 1'b1, 32'hA2};
    hits1[2] = '{32'h0040_001C, 1'b1, 32'hA3};
    hits2[0] = '{32'h0040_0013, 1'b1, 32'hA0};
    hits2[1] = '{32'h0040_001E, 1'b1, 32'hA3};
    hits2[2] = '{32'h0040_0015, 1'b1, 32'hA1};
    hits2[3] = '{32'h0040_001B, 1'b1, 32'hA2};

    reset     = 1'b0;
    pc_F      = 32'h0040_0010;
    inv_all   = 1'b0;
    stray_ack = 1'b0;
    mem_ack_r = 1'b0;
    mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check("reset mem_req", 32'(mem_req), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset ack", 32'(inst_mem_ack_F), 32'h0);
    check("reset inst", inst_F, 32'h0);

    // Cold miss: first edge after release starts the fill.
    reset = 1'b1;
    start_miss(32'h0040_0010, "cold");
    wait_hit(32'hA0, 12, "cold");
    check("cold addr count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("cold addr seq", addr_log[i], 32'h0040_0010 + 32'(4 * i));

    for (int i = 0; i < 3; i++) begin
      step();
      pc_F = hits1[i].pc;
      #1;
      check("hit1 ack", 32'(inst_mem_ack_F), 32'(hits1[i].exp_ack));
      check("hit1 inst", inst_F, hits1[i].exp_inst);
      check("hit1 mem_req", 32'(mem_req), 32'h0);
    end
    step();
`ifdef ICACHE_STATS_EN
    check("stats hit_count", hit_count, 32'd4);
    check("stats miss_count", miss_count, 32'd1);
`endif

    for (int i = 0; i < 4; i++) begin
      pc_F = hits2[i].pc;
      #1;
      check("hit2 ack", 32'(inst_mem_ack_F), 32'(hits2[i].exp_ack));
      check("hit2 inst", inst_F, hits2[i].exp_inst);
      step();
    end

    // Stray ack while idle must be ignored.
    stray_ack = 1'b1;
    #1;
    check("stray ack hit", 32'(inst_mem_ack_F), 32'h1);
    step();
    stray_ack = 1'b0;
    #1;
    check("stray ack mem_req", 32'(mem_req), 32'h0);
    check("stray ack inst", inst_F, 32'hA2);

    // Conflict eviction on line index 1.
    step();
    base = addr_log.size();
    start_miss(32'h0040_0110, "evict");
    wait_hit(~32'h0040_0110, 12, "evict");
    check("evict first addr", addr_log[base], 32'h0040_0110);
    check("evict last addr", addr_log[base + 3], 32'h0040_011C);
    step();
    start_miss(32'h0040_0010, "evicted line");
    wait_hit(32'hA0, 12, "evicted refill");

    // Top-of-memory line: fill starts at word 0 and stops at 0xFFFFFFFC.
    step();
    base = addr_log.size();
    start_miss(32'hFFFF_FFF8, "top");
    wait_hit(32'h0000_0007, 12, "top");
    check("top addr w0", addr_log[base], 32'hFFFF_FFF0);
    check("top addr w3", addr_log[base + 3], 32'hFFFF_FFFC);
    check("top addr count", 32'(addr_log.size() - base), 32'd4);
    pc_F = 32'hFFFF_FFFC;
    #1;
    check("top last word", inst_F, 32'h0000_0003);
    step();
    pc_F = 32'h0040_0010;
    #1;
    check("line1 still valid", 32'(inst_mem_ack_F), 32'h1);

    // inv_all after the 2nd ack: request held until the pending ack, then IDLE.
    step();
    base = addr_log.size();
    start_miss(32'h0040_0210, "inv fill");
    guard = 0;
    while (guard < 100 && !((addr_log.size() >= base + 2) && !mem_ack_r)) begin
      step();
      guard++;
    end
    check("inv fill reached 2 acks", 32'(guard < 100), 32'h1);
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    #1;
    check("waitdrop mem_req held", 32'(mem_req), 32'h1);
    check("waitdrop ack", 32'(inst_mem_ack_F), 32'h0);
    guard = 0;
    while (guard < 100 && mem_req) begin
      step();
      guard++;
    end
    check("waitdrop released", 32'(mem_req), 32'h0);
    check("waitdrop ack count", 32'(addr_log.size() - base), 32'd3);
    check("inv line stays invalid", 32'(inst_mem_ack_F), 32'h0);
    wait_hit(~32'h0040_0210, -1, "after inv");

    // inv_all together with the last ack: line must not become valid.
    step();
    base = addr_log.size();
    start_miss(32'h0040_0010, "inv last");
    guard = 0;
    while (guard < 100 && !((addr_log.size() >= base + 4) && mem_ack_r)) begin
      step();
      guard++;
    end
    check("inv last reached", 32'(guard < 100), 32'h1);
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    #1;
    check("inv last mem_req", 32'(mem_req), 32'h0);
    check("inv last not valid", 32'(inst_mem_ack_F), 32'h0);
    wait_hit(32'hA0, -1, "inv last refill");

    // inv_all in IDLE on a hit: ack masked that cycle, line gone afterwards.
    inv_all = 1'b1;
    #1;
    check("idle inv ack", 32'(inst_mem_ack_F), 32'h0);
    check("idle inv inst", inst_F, 32'h0);
    step();
    inv_all = 1'b0;
    #1;
    check("idle inv cleared", 32'(inst_mem_ack_F), 32'h0);
    wait_hit(32'hA0, -1, "idle inv refill");

    // Reset mid-fill: request drops at once, previously valid line misses.
    step();
    start_miss(32'h0040_0020, "rst fill");
    guard = 0;
    while (guard < 20 && !mem_req) begin
      step();
      guard++;
    end
    check("rst fill started", 32'(mem_req), 32'h1);
    step();
    reset = 1'b0;
    #1;
    check("rst mem_req async", 32'(mem_req), 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst ack", 32'(inst_mem_ack_F), 32'h0);
    step();
    pc_F  = 32'h0040_0010;
    reset = 1'b1;
    #1;
    check("post rst miss", 32'(inst_mem_ack_F), 32'h0);
    wait_hit(32'hA0, 12, "post rst");

    check("mem_addr stable", 32'(stab_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
